// File: rtl/jt89_pkg.sv
// Shared constants for the PSG volume decoder.
// Includes the amplitude table, the code thresholds and the FSM state encodings.
package jt89_pkg;

  localparam logic [8:0] VOL_AMP [0:15] = '{
    9'd511, 9'd406, 9'd322, 9'd256, 9'd162, 9'd128, 9'd102, 9'd81,
    9'd64,  9'd51,  9'd41,  9'd32,  9'd26,  9'd20,  9'd16,  9'd0
  };

  // Midpoints between neighbouring table entries; a tie resolves to the louder code
  localparam logic [8:0] VOL_THR [0:14] = '{
    9'd459, 9'd364, 9'd289, 9'd209, 9'd145, 9'd115, 9'd92, 9'd73,
    9'd58,  9'd46,  9'd37,  9'd29,  9'd23,  9'd18,  9'd8
  };

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MEAS = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

endpackage

// File: rtl/jt89_vol_map.sv
// Combinational amplitude -> 4-bit attenuation code (nearest table entry).
// The exact-match flag exists only when JT89_VOL_DEC_STRICT_EN is defined.
module jt89_vol_map (
  input  logic [8:0] amp,
  output logic [3:0] code
`ifdef JT89_VOL_DEC_STRICT_EN
  , output logic     exact
`endif
);
  import jt89_pkg::*;

  logic [14:0] ge;

  generate
    for (genvar gi = 0; gi < 15; gi++) begin : g_thr
      assign ge[gi] = amp >= VOL_THR[gi];
    end
  endgenerate

  // Thresholds descend, so the lowest set index is the loudest matching code
  always_comb begin
    code = 4'd15;
    for (int k = 14; k >= 0; k--) begin
      if (ge[k]) code = 4'(k);
    end
  end

`ifdef JT89_VOL_DEC_STRICT_EN
  assign exact = (code != 4'd15) && (amp == VOL_AMP[code]);
`endif

endmodule

// File: rtl/jt89_vol_dec.sv
// Per-channel volume/period decoder tap for the PSG.
// Define JT89_VOL_DEC_STRICT_EN to enable the sticky amplitude-mismatch flag (err).
module jt89_vol_dec #(
  parameter int PW      = 11,
  parameter int TIMEOUT = 2**PW-1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic [8:0]    snd,
  output logic          din_rec,
  output logic [3:0]    vol,
  output logic [PW-1:0] period,
  output logic          valid,
  output logic          upd,
  output logic          err
);
  import jt89_pkg::*;

  localparam logic [PW-1:0] CNT_MAX = {PW{1'b1}};
  localparam logic [PW-1:0] TO      = PW'(TIMEOUT);

  logic          d;
  logic          rise;
  logic [1:0]    state;
  logic [PW-1:0] cnt;
  logic [8:0]    peak;
  logic [3:0]    peak_code;

  assign d    = |snd;
  assign rise = d & ~din_rec;

`ifdef JT89_VOL_DEC_STRICT_EN
  logic       exact;
  logic [8:0] snd_prev;

  jt89_vol_map u_map (
    .amp   (peak),
    .code  (peak_code),
    .exact (exact)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err      <= 1'b0;
      snd_prev <= 9'd0;
    end else if (clk_en) begin
      snd_prev <= snd;
      // Off-table peak at a measured edge, or a level change inside one high phase
      if ((state != IDLE && rise && !exact) || (d && din_rec && snd != snd_prev))
        err <= 1'b1;
    end
  end
`else
  jt89_vol_map u_map (
    .amp  (peak),
    .code (peak_code)
  );

  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      din_rec <= 1'b0;
      vol     <= 4'd15;
      period  <= '0;
      valid   <= 1'b0;
      upd     <= 1'b0;
      cnt     <= '0;
      peak    <= 9'd0;
      state   <= IDLE;
    end else begin
      upd <= 1'b0;
      if (clk_en) begin
        din_rec <= d;
        if (rise) begin
          cnt  <= {{(PW-1){1'b0}}, 1'b1};
          peak <= snd;
        end else begin
          cnt  <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          peak <= (snd > peak) ? snd : peak;
        end

        case (state)
          IDLE: if (rise) state <= MEAS;
          MEAS, LOCK: begin
            // cnt and peak still describe the period that this edge closes
            if (rise) begin
              state  <= LOCK;
              period <= cnt;
              vol    <= peak_code;
              upd    <= 1'b1;
              valid  <= 1'b1;
            end else if (cnt >= TO) begin
              state  <= IDLE;
              vol    <= 4'd15;
              period <= '0;
              valid  <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
